// File: rtl/ch_pkg.sv
// ch_pkg: shared types for cluster-head table and selection logic
package ch_pkg;
    localparam int CH_WORD_WIDTH = 16;
    localparam logic [CH_WORD_WIDTH-1:0] CH_ID_NONE = '0;
    typedef struct packed {
        logic [CH_WORD_WIDTH-1:0] id;
        logic [CH_WORD_WIDTH-1:0] hops;
        logic [CH_WORD_WIDTH-1:0] qvalue;
    } ch_entry_t;
    typedef enum logic [1:0] {SEL_IDLE, SEL_SCAN, SEL_DONE} sel_state_t;
endpackage

// File: rtl/ch_compare.sv
// ch_compare: candidate-vs-best CH ranking (fewer hops, then higher Q, then lower ID)
module ch_compare #(
    parameter int W = 16
) (
    input  logic         cand_valid,
    input  logic [W-1:0] cand_id,
    input  logic [W-1:0] cand_hops,
    input  logic [W-1:0] cand_q,
    input  logic         best_valid,
    input  logic [W-1:0] best_id,
    input  logic [W-1:0] best_hops,
    input  logic [W-1:0] best_q,
    output logic         better
);
    always_comb
        better = cand_valid && (!best_valid || cand_hops < best_hops ||
                 (cand_hops == best_hops && (cand_q > best_q ||
                 (cand_q == best_q && cand_id < best_id))));
endmodule

// File: rtl/ch_table_selector.sv
// ch_table_selector: known-CH table with dedup on write and sequential best-CH scan
module ch_table_selector
    import ch_pkg::*;
#(
    parameter int WORD_WIDTH = 16,
    parameter int NUM_ENTRIES = 16,
    localparam int IDX_WIDTH = $clog2(NUM_ENTRIES)
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  HB_reset,
    input  logic                  en_KCH,
    input  logic [WORD_WIDTH-1:0] fCH_ID,
    input  logic [WORD_WIDTH-1:0] fCH_Hops,
    input  logic [WORD_WIDTH-1:0] fCH_QValue,
    input  logic                  sel_start,
    output logic                  sel_busy,
    output logic                  sel_valid,
    output logic [WORD_WIDTH-1:0] chosenCH,
    output logic [WORD_WIDTH-1:0] hopsfromCH,
    output logic [WORD_WIDTH-1:0] chosenQ,
    output logic [IDX_WIDTH:0]    entry_count,
    output logic                  table_full,
    output logic                  overflow
);
    typedef struct packed {
        logic [WORD_WIDTH-1:0] id;
        logic [WORD_WIDTH-1:0] hops;
        logic [WORD_WIDTH-1:0] qvalue;
    } entry_t;

    entry_t                 ent [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] vld;
    entry_t                 best;
    logic                   best_vld;
    logic [IDX_WIDTH-1:0]   idx;
    logic [IDX_WIDTH:0]     limit;
    sel_state_t             state;
    logic                   hit;
    logic [IDX_WIDTH-1:0]   hit_idx;
    logic                   better;

    assign table_full = entry_count == (IDX_WIDTH+1)'(NUM_ENTRIES);

    always_comb begin
        hit = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < NUM_ENTRIES; i++)
            if (vld[i] && ent[i].id == fCH_ID) begin
                hit = 1'b1;
                hit_idx = IDX_WIDTH'(i);
            end
    end

    ch_compare #(.W(WORD_WIDTH)) u_cmp (
        .cand_valid(vld[idx]),
        .cand_id   (ent[idx].id),
        .cand_hops (ent[idx].hops),
        .cand_q    (ent[idx].qvalue),
        .best_valid(best_vld),
        .best_id   (best.id),
        .best_hops (best.hops),
        .best_q    (best.qvalue),
        .better    (better)
    );

    always_ff @(posedge clk) begin
        if (!nrst || HB_reset) begin
            for (int i = 0; i < NUM_ENTRIES; i++)
                ent[i] <= '0;
            vld <= '0;
            entry_count <= '0;
            overflow <= 1'b0;
            state <= SEL_IDLE;
            sel_busy <= 1'b0;
            sel_valid <= 1'b0;
            chosenCH <= '0;
            hopsfromCH <= '1;
            chosenQ <= '0;
            best <= '0;
            best_vld <= 1'b0;
            idx <= '0;
            limit <= '0;
        end else begin
            if (en_KCH && fCH_ID != '0) begin
                if (hit) begin
                    ent[hit_idx].hops <= fCH_Hops;
                    ent[hit_idx].qvalue <= fCH_QValue;
                end else if (!table_full) begin
                    ent[entry_count[IDX_WIDTH-1:0]] <= '{fCH_ID, fCH_Hops, fCH_QValue};
                    vld[entry_count[IDX_WIDTH-1:0]] <= 1'b1;
                    entry_count <= entry_count + 1'b1;
                end else
                    overflow <= 1'b1;
            end
            sel_valid <= 1'b0;
            case (state)
                SEL_IDLE:
                    if (sel_start) begin
                        limit <= entry_count;
                        idx <= '0;
                        best_vld <= 1'b0;
                        sel_busy <= entry_count != '0;
                        state <= entry_count == '0 ? SEL_DONE : SEL_SCAN;
                    end
                SEL_SCAN: begin
                    if (better) begin
                        best <= ent[idx];
                        best_vld <= 1'b1;
                    end
                    idx <= idx + 1'b1;
                    if ({1'b0, idx} == limit - 1'b1) begin
                        sel_busy <= 1'b0;
                        state <= SEL_DONE;
                    end
                end
                default: begin
                    chosenCH <= best_vld ? best.id : '0;
                    hopsfromCH <= best_vld ? best.hops : '1;
                    chosenQ <= best_vld ? best.qvalue : '0;
                    sel_valid <= 1'b1;
                    state <= SEL_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ch_table_selector.sv
// tb_ch_table_selector: directed vector table plus multi-cycle corner sequences
module tb_ch_table_selector;
    logic        clk = 0, nrst = 0, HB_reset = 0, en_KCH = 0, sel_start = 0;
    logic [15:0] fCH_ID = 0, fCH_Hops = 0, fCH_QValue = 0;
    logic        sel_busy, sel_valid, table_full, overflow;
    logic [15:0] chosenCH, hopsfromCH, chosenQ;
    logic [4:0]  entry_count;
    int          checks = 0, errors = 0;

    ch_table_selector dut (
        .clk(clk), .nrst(nrst), .HB_reset(HB_reset), .en_KCH(en_KCH),
        .fCH_ID(fCH_ID), .fCH_Hops(fCH_Hops), .fCH_QValue(fCH_QValue),
        .sel_start(sel_start), .sel_busy(sel_busy), .sel_valid(sel_valid),
        .chosenCH(chosenCH), .hopsfromCH(hopsfromCH), .chosenQ(chosenQ),
        .entry_count(entry_count), .table_full(table_full), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] id [3];
        logic [15:0] h [3];
        logic [15:0] q [3];
        logic [15:0] ech, eh, eq;
        int          ecnt, elat;
    } vec_t;

    function automatic vec_t mk(input logic [15:0] i0, h0, q0, i1, h1, q1, i2, h2, q2,
                                input logic [15:0] ech, eh, eq, input int ecnt, elat);
        vec_t v;
        v.id[0] = i0; v.h[0] = h0; v.q[0] = q0;
        v.id[1] = i1; v.h[1] = h1; v.q[1] = q1;
        v.id[2] = i2; v.h[2] = h2; v.q[2] = q2;
        v.ech = ech; v.eh = eh; v.eq = eq; v.ecnt = ecnt; v.elat = elat;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] id, input logic [15:0] h, input logic [15:0] q);
        fCH_ID = id; fCH_Hops = h; fCH_QValue = q; en_KCH = 1;
        tick();
        en_KCH = 0;
    endtask

    task automatic hb();
        HB_reset = 1;
        tick();
        HB_reset = 0;
    endtask

    task automatic sel(output int lat, output logic busy1);
        sel_start = 1;
        tick();
        sel_start = 0;
        busy1 = sel_busy;
        lat = 1;
        while (!sel_valid && lat < 200) begin
            tick();
            lat++;
        end
    endtask

    vec_t vt [5];
    int   lat;
    logic b;
    logic seen;

    initial begin
        vt[0] = mk(5, 3, 10, 7, 2, 1, 9, 4, 99, 7, 2, 1, 3, 5);
        vt[1] = mk(4, 2, 50, 3, 2, 50, 8, 2, 40, 3, 2, 50, 3, 5);
        vt[2] = mk(10, 1, 5, 11, 1, 9, 12, 2, 100, 11, 1, 9, 3, 5);
        vt[3] = mk(6, 5, 5, 6, 1, 1, 2, 3, 3, 6, 1, 1, 2, 4);
        vt[4] = mk(16'hFFFF, 16'hFFFE, 0, 1, 16'hFFFF, 16'hFFFF, 0, 0, 0, 16'hFFFF, 16'hFFFE, 0, 2, 4);

        repeat (2) tick();
        nrst = 1;
        chk("rst_chosen", chosenCH, 0);
        chk("rst_hops", hopsfromCH, 16'hFFFF);
        chk("rst_q", chosenQ, 0);
        chk("rst_count", entry_count, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_busy", sel_busy, 0);
        chk("rst_valid", sel_valid, 0);

        sel(lat, b);
        chk("empty_lat", lat, 2);
        chk("empty_busy", b, 0);
        chk("empty_chosen", chosenCH, 0);
        chk("empty_hops", hopsfromCH, 16'hFFFF);

        foreach (vt[k]) begin
            hb();
            for (int j = 0; j < 3; j++) wr(vt[k].id[j], vt[k].h[j], vt[k].q[j]);
            chk($sformatf("v%0d_count", k), entry_count, vt[k].ecnt);
            sel(lat, b);
            chk($sformatf("v%0d_lat", k), lat, vt[k].elat);
            chk($sformatf("v%0d_busy", k), b, 1);
            chk($sformatf("v%0d_chosen", k), chosenCH, vt[k].ech);
            chk($sformatf("v%0d_hops", k), hopsfromCH, vt[k].eh);
            chk($sformatf("v%0d_q", k), chosenQ, vt[k].eq);
            tick();
            chk($sformatf("v%0d_pulse", k), sel_valid, 0);
            chk($sformatf("v%0d_hold", k), chosenCH, vt[k].ech);
        end

        hb();
        wr(4, 2, 50); wr(3, 2, 50); wr(8, 2, 40);
        sel(lat, b);
        chk("tie_chosen", chosenCH, 3);
        wr(8, 2, 60);
        chk("tie_upd_count", entry_count, 3);
        sel(lat, b);
        chk("tie_upd_chosen", chosenCH, 8);
        chk("tie_upd_q", chosenQ, 60);

        hb();
        for (int i = 1; i <= 16; i++) wr(16'(i), 5, 16'(i));
        chk("full_flag", table_full, 1);
        chk("full_no_ovf", overflow, 0);
        wr(17, 1, 0);
        chk("full_ovf", overflow, 1);
        chk("full_count", entry_count, 16);
        sel(lat, b);
        chk("full_lat", lat, 18);
        chk("full_chosen", chosenCH, 16);
        wr(0, 0, 0);
        chk("id0_count", entry_count, 16);
        wr(3, 1, 0);
        sel(lat, b);
        chk("full_upd_chosen", chosenCH, 3);
        chk("full_upd_hops", hopsfromCH, 1);
        chk("full_ovf_sticky", overflow, 1);

        sel_start = 1;
        tick();
        sel_start = 0;
        tick();
        tick();
        chk("mid_busy", sel_busy, 1);
        hb();
        seen = 0;
        repeat (25) begin
            if (sel_valid) seen = 1;
            tick();
        end
        chk("abort_no_valid", seen, 0);
        chk("abort_count", entry_count, 0);
        chk("abort_ovf", overflow, 0);
        chk("abort_chosen", chosenCH, 0);
        chk("abort_hops", hopsfromCH, 16'hFFFF);
        chk("abort_busy", sel_busy, 0);

        HB_reset = 1; en_KCH = 1; fCH_ID = 5; fCH_Hops = 1; fCH_QValue = 1;
        tick();
        HB_reset = 0; en_KCH = 0;
        chk("hb_wr_count", entry_count, 0);
        sel(lat, b);
        chk("hb_wr_lat", lat, 2);
        chk("hb_wr_chosen", chosenCH, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
